// File: rtl/gene_net_pkg.sv
// Shared types for the gene network trajectory analyzer.
// Holds the default state width, the analyzer FSM encoding and the step type.
// No logic; imported by the table and the analyzer.
package gene_net_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    REPORT
  } attr_state_t;

  // One bit wider than the state so a full 2^W run never wraps.
  typedef logic [W_DEFAULT:0] step_t;

endpackage

// File: rtl/visit_table.sv
// First-visit table: one visited bit and one W+1 bit step index per state.
// Combinational read of registered storage; writes land on the sampling edge.
// Bulk clear takes one cycle and wins over a same-cycle write.
module visit_table #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         we_i,
  input  logic [W-1:0] waddr_i,
  input  logic [W:0]   wdata_i,
  input  logic [W-1:0] raddr_i,
  output logic         rvisited_o,
  output logic [W:0]   ridx_o
);

  localparam int N = 1 << W;

  logic [N-1:0] visited_q;
  logic [W:0]   idx_q [N];

  // Visited bits: the only state that needs clearing, since idx is read only behind a set bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      visited_q <= '0;
    end else if (clr_i) begin
      visited_q <= '0;
    end else if (we_i) begin
      visited_q[waddr_i] <= 1'b1;
    end
  end

  // Step index storage, plain RAM without reset.
  always_ff @(posedge clk) begin
    if (we_i && !clr_i) begin
      idx_q[waddr_i] <= wdata_i;
    end
  end

  assign rvisited_o = visited_q[raddr_i];
  assign ridx_o     = idx_q[raddr_i];

endmodule

// File: rtl/attractor_analyzer.sv
// Tracks a state trajectory and reports its attractor (entry, period, transient).
// One sample per cycle in TRACK; result appears the cycle after the first repeat.
// Result is held in REPORT until res_valid && res_ready; start always restarts.
module attractor_analyzer
  import gene_net_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         x_valid,
  input  logic [W-1:0] x,
  output logic         busy,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         is_fixed,
  output logic [W:0]   period,
  output logic [W:0]   transient,
  output logic [W-1:0] attractor
);

  attr_state_t  state_q;
  logic [W:0]   step_q;
  logic         busy_q;
  logic         res_valid_q;
  logic         is_fixed_q;
  logic [W:0]   period_q;
  logic [W:0]   transient_q;
  logic [W-1:0] attractor_q;

  logic         hit_visited;
  logic [W:0]   hit_idx;
  logic         sample_en;
  logic         tbl_we;
  logic [W:0]   period_d;

  // A sample counts only in TRACK and never in the same cycle as start.
  assign sample_en = (state_q == TRACK) && x_valid && !start;
  assign tbl_we    = sample_en && !hit_visited;
  assign period_d  = step_q - hit_idx;

  visit_table #(.W(W)) u_visit_table (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (start),
    .we_i       (tbl_we),
    .waddr_i    (x),
    .wdata_i    (step_q),
    .raddr_i    (x),
    .rvisited_o (hit_visited),
    .ridx_o     (hit_idx)
  );

  // Control FSM with step counter and registered result/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      is_fixed_q  <= 1'b0;
      period_q    <= '0;
      transient_q <= '0;
      attractor_q <= '0;
    end else if (start) begin
      state_q     <= TRACK;
      step_q      <= '0;
      busy_q      <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        TRACK: begin
          if (sample_en) begin
            if (hit_visited) begin
              attractor_q <= x;
              transient_q <= hit_idx;
              period_q    <= period_d;
              is_fixed_q  <= (period_d == (W+1)'(1));
              busy_q      <= 1'b0;
              res_valid_q <= 1'b1;
              state_q     <= REPORT;
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign is_fixed  = is_fixed_q;
  assign period    = period_q;
  assign transient = transient_q;
  assign attractor = attractor_q;

endmodule

// File: tb/tb_attractor_analyzer.sv
// Directed bench for attractor_analyzer with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are checked at the same point.
// Ends with one summary line of comparisons and mismatches.
module tb_attractor_analyzer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         x_valid;
  logic [W-1:0] x;
  logic         busy;
  logic         res_valid;
  logic         res_ready;
  logic         is_fixed;
  logic [W:0]   period;
  logic [W:0]   transient;
  logic [W-1:0] attractor;

  int n_cmp = 0;
  int n_bad = 0;

  attractor_analyzer #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_valid   (x_valid),
    .x         (x),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .is_fixed  (is_fixed),
    .period    (period),
    .transient (transient),
    .attractor (attractor)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One trajectory sample per call, back to back when called in sequence.
  task automatic send(input logic [W-1:0] v);
    x_valid = 1'b1;
    x       = v;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic fx, input logic [W:0] per,
                            input logic [W:0] tr, input logic [W-1:0] att);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd1);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".is_fixed"},  32'(is_fixed),  32'(fx));
    chk({tag, ".period"},    32'(period),    32'(per));
    chk({tag, ".transient"}, 32'(transient), 32'(tr));
    chk({tag, ".attractor"}, 32'(attractor), 32'(att));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, ".is_fixed"},  32'(is_fixed),  32'd0);
    chk({tag, ".period"},    32'(period),    32'd0);
    chk({tag, ".transient"}, 32'(transient), 32'd0);
    chk({tag, ".attractor"}, 32'(attractor), 32'd0);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; x_valid = 1'b0; x = '0; res_ready = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      start     = 1'($urandom);
      x_valid   = 1'($urandom);
      x         = W'($urandom);
      res_ready = 1'($urandom);
      tick();
    end
    chk_zero("reset");
    start = 1'b0; x_valid = 1'b0; res_ready = 1'b0; x = '0;
    rst = 1'b0;
    tick();
    chk_zero("idle_after_reset");

    // IDLE ignores samples.
    send(8'h05);
    send(8'h05);
    chk_zero("idle_ignores_x");

    // Fixed point: start then 00, 00.
    pulse_start();
    chk("fix.busy_rise", 32'(busy), 32'd1);
    chk("fix.res_valid_early0", 32'(res_valid), 32'd0);
    send(8'h00);
    chk("fix.res_valid_early1", 32'(res_valid), 32'd0);
    chk("fix.busy_mid", 32'(busy), 32'd1);
    send(8'h00);
    chk_result("fix", 1'b1, 9'd1, 9'd0, 8'h00);
    accept();
    chk("fix.res_valid_drop", 32'(res_valid), 32'd0);
    chk("fix.busy_idle", 32'(busy), 32'd0);

    // Cycle: 38, 1C, B2, 1C -> period 2, transient 1.
    pulse_start();
    send(8'h38);
    send(8'h1C);
    send(8'hB2);
    send(8'h1C);
    chk_result("cyc", 1'b0, 9'd2, 9'd1, 8'h1C);

    // Handshake hold with random samples presented.
    for (int i = 0; i < 5; i++) begin
      x_valid = 1'b1;
      x       = W'($urandom);
      tick();
      chk_result("hold", 1'b0, 9'd2, 9'd1, 8'h1C);
    end
    x_valid = 1'b0;
    accept();
    chk("hold.res_valid_drop", 32'(res_valid), 32'd0);
    chk("hold.busy_idle", 32'(busy), 32'd0);
    // Still IDLE: a repeat of 1C must not produce a result.
    send(8'h1C);
    send(8'h1C);
    chk("hold.idle_res_valid", 32'(res_valid), 32'd0);
    chk("hold.idle_busy", 32'(busy), 32'd0);

    // Restart mid-TRACK forgets earlier visits.
    pulse_start();
    send(8'h01);
    send(8'h02);
    send(8'h03);
    pulse_start();
    send(8'h03);
    chk("rst_run.busy", 32'(busy), 32'd1);
    send(8'h03);
    chk_result("restart", 1'b1, 9'd1, 9'd0, 8'h03);

    // Start with res_ready in REPORT drops the result; coincident sample ignored.
    start = 1'b1; res_ready = 1'b1; x_valid = 1'b1; x = 8'h55;
    tick();
    start = 1'b0; res_ready = 1'b0; x_valid = 1'b0;
    chk("drop.busy", 32'(busy), 32'd1);
    chk("drop.res_valid", 32'(res_valid), 32'd0);
    send(8'h55);
    chk("drop.no_early_hit", 32'(res_valid), 32'd0);
    send(8'h56);
    send(8'h55);
    chk_result("drop", 1'b0, 9'd2, 9'd0, 8'h55);
    accept();

    // Full range 00..FF then 00 -> period 256.
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      send(W'(i));
      chk("full.busy", 32'(busy), 32'd1);
    end
    send(8'h00);
    chk_result("full", 1'b0, 9'd256, 9'd0, 8'h00);
    accept();
    chk("full.res_valid_drop", 32'(res_valid), 32'd0);

    // Reset mid-TRACK after a result exists.
    pulse_start();
    send(8'h01);
    send(8'h02);
    chk("mid.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_zero("mid_async");
    tick();
    chk_zero("mid_reset");
    rst = 1'b0;
    send(8'h02);
    send(8'h02);
    chk_zero("mid_idle");
    pulse_start();
    send(8'h02);
    send(8'h01);
    send(8'h02);
    chk_result("post_reset", 1'b0, 9'd2, 9'd0, 8'h02);
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/attractor_analyzer.md
# attractor_analyzer

Downstream consumer of the gene network trajectory. It takes the state sequence `x` produced by `gene_net`, one sample per `x_valid` cycle, and records when each state was first visited. On the first revisit it reports the attractor: fixed point or cycle, period, transient length and entry state. This supersedes the single-purpose `fixed_point_checker` / `cycle` flags with one measured result per trajectory.

## Interface
- `W`, default 8: network state width; the table holds 2^W entries.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle pulse that begins a new trajectory, clears the table and aborts any run in progress.
- `x_valid` input 1: `x` carries the next trajectory state this cycle.
- `x` input W: network state, connected to `gene_net.x_out`.
- `busy` output 1: high while tracking (state TRACK).
- `res_valid` output 1: result fields are valid.
- `res_ready` input 1: consumer accepts the result.
- `is_fixed` output 1: attractor period == 1.
- `period` output W+1: cycle length, 1..2^W.
- `transient` output W+1: number of samples before the attractor is entered, 0..2^W-1.
- `attractor` output W: the first repeated state (entry point of the attractor).

## Operation
- States are IDLE, TRACK and REPORT. Reset puts the block in IDLE.
- IDLE:
  - `start` goes to TRACK. The same edge clears all 2^W visited bits and sets `step`=0.
  - `x_valid` is ignored.
- TRACK, on each `x_valid`, look up `x`:
  - If `visited[x]`=0: write `idx[x]`=`step`, set `visited[x]`, then `step`++.
  - If `visited[x]`=1: latch `attractor`=`x`, `transient`=`idx[x]`, `period`=`step`−`idx[x]` and `is_fixed`=(`period`==1). Go to REPORT.
- Width rule:
  - By pigeonhole a repeat occurs by sample 2^W+1, so `step` never exceeds 2^W.
  - `step`, `idx` entries, `period` and `transient` are W+1 bits and never wrap.
- REPORT:
  - `res_valid`=1 and all result fields are held stable until `res_valid`&&`res_ready`. That handshake returns to IDLE.
  - `x_valid` is ignored.
- `start` has priority in every state:
  - In TRACK it restarts the run.
  - In REPORT it discards the unaccepted result and restarts.
  - `start` together with `res_ready` in REPORT counts as a restart; the result is dropped.
- A sample presented with `x_valid` in the same cycle as `start` is ignored. The first tracked sample is the one after `start`.
- Reset mid-operation: immediate return to IDLE, all visited bits cleared, outputs at their reset values.

## Timing
- Reset values: `busy`=0, `res_valid`=0, `is_fixed`=0, `period`=0, `transient`=0, `attractor`=0.
- `busy` rises the cycle after `start` is sampled.
- Table lookup is a combinational read of registered storage. Table writes complete at the sampling edge.
- Result latency: `res_valid` rises the cycle after the repeating sample is sampled, with `busy` falling in the same cycle.
- `res_valid` falls the cycle after the `res_valid`&&`res_ready` handshake.
- Throughput: one sample per cycle, no stalls in TRACK.
- Minimum run is `start` followed by two samples (a fixed point), giving `res_valid` 3 cycles after `start`.

## Structure
- Package `gene_net_pkg` holds:
  - `W_DEFAULT`=8.
  - The state enum `attr_state_t` {IDLE, TRACK, REPORT}.
  - The `step_t` typedef (W+1 bits).
- Sub-module `visit_table` contains:
  - The 2^W × (W+1) `idx` array and the 2^W visited bit vector.
  - Single-cycle bulk clear, one combinational read port and one write port.
- `attractor_analyzer` holds the FSM, the step counter and the result registers.

## Test plan
- Reset: hold `rst` 3 cycles with random inputs → all outputs 0 and `busy`=0. Assert `rst` mid-TRACK → back to IDLE next edge, outputs 0.
- Fixed point: `start`, then `x`=0x00, 0x00 → `res_valid`, `is_fixed`=1, `period`=1, `transient`=0, `attractor`=0x00.
- Cycle: `start`, then 0x38, 0x1C, 0xB2, 0x1C → `is_fixed`=0, `period`=2, `transient`=1, `attractor`=0x1C.
- Full range: `start`, then 0x00..0xFF (256 samples) followed by 0x00 → `period`=256, `transient`=0, `busy` held through all 257 samples.
- Handshake hold: hold `res_ready`=0 for 5 cycles while driving `x_valid` with random `x` → result fields stable and unchanged. `res_ready`=1 → `res_valid` drops the next cycle and state is IDLE.
- Restart:
  - `start` after 3 samples of 0x01, 0x02, 0x03, then 0x03, 0x03 → `period`=1, `transient`=0; the earlier visits are forgotten.
  - `start` coincident with `res_ready` → result dropped and `busy`=1 the next cycle.
